// File: rtl/fetch_pkg.sv
// Shared fetch-side types and helpers.
// legal_pc is also used by the branch unit to vet targets.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } fetch_state_t;

  // Word aligned and inside the 2**addr_w word ROM.
  function automatic logic legal_pc(
    input logic [XLEN-1:0] pc,
    input int unsigned addr_w
  );
    logic [XLEN-1:0] hi;
    hi = pc >> (addr_w + 2);
    return (pc[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready slot.
// master = fetch side, slave = decode side.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and ROM initiator; feeds decode via a one-entry slot.
// Stops on the halt word, takes redirects, faults on bad addresses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int XLEN = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  instr_fetch_unit_if.master out,
  output logic              halted,
  output logic              fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic [XLEN-1:0] oin_q, oin_d;
  logic            ov_q, ov_d;
  logic            can_load;
  logic            tgt_ok;
  logic            pc_ok;

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign can_load = !ov_q || out.out_ready;
  assign tgt_ok = legal_pc(redirect_pc, ADDR_W);
  assign pc_ok = legal_pc(pc_q, ADDR_W);

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    opc_d = opc_q;
    oin_d = oin_q;
    ov_d = ov_q;
    if (redirect_valid && state_q != FAULT) begin
      ov_d = 1'b0;
      if (tgt_ok) begin
        pc_d = redirect_pc;
        state_d = RUN;
      end else begin
        state_d = FAULT;
      end
    end else if (state_q == RUN && can_load) begin
      // pc walked off the ROM: fault rather than alias to word 0
      if (!pc_ok) begin
        state_d = FAULT;
        ov_d = 1'b0;
      end else if (rom_instr == HALT_WORD) begin
        state_d = HALT;
        ov_d = 1'b0;
      end else begin
        opc_d = pc_q;
        oin_d = rom_instr;
        ov_d = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
    end else if (out.out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= '0;
      opc_q <= '0;
      oin_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      opc_q <= opc_d;
      oin_q <= oin_d;
      ov_q <= ov_d;
    end
  end

  assign out.out_valid = ov_q;
  assign out.out_pc = opc_q;
  assign out.out_instr = oin_q;
  assign halted = (state_q == HALT);
  assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Spec-level model compared every negedge plus directed literal checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic        fault;
  logic [31:0] rom [32];

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out(bus.master),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  assign rom_instr = rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec model: 0=RUN 1=HALT 2=FAULT
  int          m_state;
  logic [31:0] m_pc, m_opc, m_oin;
  logic        m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_pc = 0; m_opc = 0; m_oin = 0; m_valid = 0;
    end else if (redirect_valid && m_state != 2) begin
      m_valid = 0;
      if (redirect_pc % 4 == 0 && redirect_pc < 128) begin
        m_pc = redirect_pc;
        m_state = 0;
      end else begin
        m_state = 2;
      end
    end else if (m_state == 0 && (!m_valid || bus.out_ready)) begin
      if (m_pc >= 128 || m_pc % 4 != 0) begin
        m_state = 2; m_valid = 0;
      end else if (rom[m_pc / 4] == 32'hFFFF_FFFF) begin
        m_state = 1; m_valid = 0;
      end else begin
        m_opc = m_pc; m_oin = rom[m_pc / 4]; m_valid = 1; m_pc = m_pc + 4;
      end
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  end

  logic [31:0] acc[$];
  bit          logging = 0;

  always @(negedge clk) begin
    chk("m_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk("m_pc", bus.out_pc, m_opc);
    chk("m_instr", bus.out_instr, m_oin);
    chk("m_halted", {31'b0, halted}, {31'b0, m_state == 1});
    chk("m_fault", {31'b0, fault}, {31'b0, m_state == 2});
    chk("m_addr", {27'b0, rom_addr}, (m_pc >> 2) % 32);
    if (logging && bus.out_valid && bus.out_ready) acc.push_back(bus.out_pc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  logic [31:0] exp1 [6];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hFFFF_FFFF;
    rom[0] = 32'h00000093; rom[1] = 32'h01000113; rom[2] = 32'h06400193;
    rom[3] = 32'h00800213; rom[4] = 32'h002082B3; rom[5] = 32'h00418333;
    exp1[0] = 32'h0; exp1[1] = 32'h4; exp1[2] = 32'h8;
    exp1[3] = 32'hC; exp1[4] = 32'h10; exp1[5] = 32'h14;
    bus.out_ready = 1'b1;

    // 1: free-running stream until halt
    tick(1);
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    rst = 1'b0;
    logging = 1;
    tick(1);
    chk("first_pc", bus.out_pc, 32'h0);
    chk("first_instr", bus.out_instr, 32'h00000093);
    tick(8);
    logging = 0;
    chk("t1_count", acc.size(), 32'd6);
    for (int i = 0; i < 6 && i < acc.size(); i++)
      chk("t1_stream", acc[i], exp1[i]);
    chk("t1_halted", {31'b0, halted}, 32'd1);
    chk("t1_valid", {31'b0, bus.out_valid}, 32'd0);

    // 2: stall on pc 8
    do_reset();
    tick(3);
    chk("t2_pc8", bus.out_pc, 32'h8);
    bus.out_ready = 1'b0;
    acc.delete();
    logging = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t2_hold_pc", bus.out_pc, 32'h8);
      chk("t2_hold_instr", bus.out_instr, 32'h06400193);
      chk("t2_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick(2);
    logging = 0;
    chk("t2_count", acc.size(), 32'd2);
    if (acc.size() >= 2) begin
      chk("t2_resume0", acc[0], 32'h8);
      chk("t2_resume1", acc[1], 32'hC);
    end

    // 3: redirect flushes the slot
    do_reset();
    tick(2);
    chk("t3_pc4", bus.out_pc, 32'h4);
    redir(32'h10);
    chk("t3_flush", {31'b0, bus.out_valid}, 32'd0);
    tick(1);
    chk("t3_pc", bus.out_pc, 32'h10);
    chk("t3_instr", bus.out_instr, 32'h002082B3);

    // 4: resume from HALT
    tick(2);
    chk("t4_halted", {31'b0, halted}, 32'd1);
    redir(32'h4);
    chk("t4_unhalt", {31'b0, halted}, 32'd0);
    tick(1);
    chk("t4_pc", bus.out_pc, 32'h4);
    chk("t4_instr", bus.out_instr, 32'h01000113);

    // 5: misaligned and out-of-range targets
    redir(32'h6);
    chk("t5a_fault", {31'b0, fault}, 32'd1);
    chk("t5a_valid", {31'b0, bus.out_valid}, 32'd0);
    redir(32'h0);
    chk("t5a_sticky", {31'b0, fault}, 32'd1);
    do_reset();
    tick(1);
    redir(32'h80);
    chk("t5b_fault", {31'b0, fault}, 32'd1);
    redir(32'h4);
    tick(1);
    chk("t5b_sticky", {31'b0, fault}, 32'd1);
    chk("t5b_valid", {31'b0, bus.out_valid}, 32'd0);

    // wrap off the last word faults instead of aliasing
    rom[31] = 32'h00000013;
    do_reset();
    redir(32'h7C);
    tick(1);
    chk("wrap_pc", bus.out_pc, 32'h7C);
    tick(1);
    chk("wrap_fault", {31'b0, fault}, 32'd1);
    chk("wrap_valid", {31'b0, bus.out_valid}, 32'd0);
    rom[31] = 32'hFFFF_FFFF;

    // 6: async reset mid-stream
    do_reset();
    tick(2);
    chk("t6_pre", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t6_pc", bus.out_pc, 32'd0);
    chk("t6_instr", bus.out_instr, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t6_first", bus.out_pc, 32'h0);
    chk("t6_first_v", {31'b0, bus.out_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
